// File: rtl/proj_sched_pkg.sv
// Shared definitions for the projector trigger scheduler.
//   state_t     : scheduler state encoding (also exported on STATE for debug)
//   C_ROW_TIME  : default burst length in CLK_HS cycles (rows * per-row preload)
//   sat_sub32   : 32-bit subtract clamped at zero
package proj_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SKIP     = 3'd1,
    S_ARM      = 3'd2,
    S_WAIT_DLY = 3'd3,
    S_PULSE    = 3'd4,
    S_HOLD     = 3'd5,
    S_FLUSH    = 3'd6
  } state_t;

  localparam int unsigned C_NUM_ROWS_DEF   = 160;
  localparam int unsigned C_MASK_DES_L_DEF = 18;
  localparam logic [31:0] C_ROW_TIME       = 32'(C_NUM_ROWS_DEF * C_MASK_DES_L_DEF);

  function automatic logic [31:0] sat_sub32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with edge detection on the synchronized level.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   level    : synchronized level (C_STAGES flops deep)
//   rise     : one-cycle pulse when level goes 0->1
//   fall     : one-cycle pulse when level goes 1->0
module sync_edge_det #(
  parameter int unsigned C_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [C_STAGES-1:0] sync_q, sync_d;
  logic                level_dly_q, level_dly_d;

  always_comb begin
    sync_d      = {sync_q[C_STAGES-2:0], d};
    level_dly_d = sync_q[C_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level = sync_q[C_STAGES-1];
  assign rise  = level & ~level_dly_q;
  assign fall  = ~level & level_dly_q;

endmodule

// File: rtl/proj_trig_sched.sv
// Projector trigger scheduler. Classifies each STREAM preload burst of a frame
// as preload (burst 0), pattern (1..NUM_PAT) or flush (NUM_PAT+1) and fires one
// TRIGGER_PROJ pulse per pattern burst, PROJ_DELAY cycles before the nominal
// burst end.
//   CLK_HS, RESET       : clock, synchronous active-high reset
//   ENABLE              : low forces IDLE and drops the trigger
//   FRAME_START         : arms one frame (only honoured in IDLE)
//   STREAM              : asynchronous preload strobe
//   PROJ_DELAY, PULSE_WIDTH, NUM_PAT : frame config, latched on arm
//   TRIGGER_PROJ        : registered projector trigger
//   PAT_IDX             : pattern bursts consumed this frame
//   BUSY, STATE         : status / debug
//   FRAME_DONE          : one-cycle end-of-frame pulse
//   OVERRUN             : sticky timing violation flag
module proj_trig_sched
  import proj_sched_pkg::*;
#(
  parameter int unsigned C_NUM_ROWS    = C_NUM_ROWS_DEF,
  parameter int unsigned C_MASK_DES_L  = C_MASK_DES_L_DEF,
  parameter int unsigned C_SYNC_STAGES = 2,
  parameter int unsigned C_PW_W        = 16
) (
  input  logic              CLK_HS,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              FRAME_START,
  input  logic              STREAM,
  input  logic [31:0]       PROJ_DELAY,
  input  logic [C_PW_W-1:0] PULSE_WIDTH,
  input  logic [31:0]       NUM_PAT,
  output logic              TRIGGER_PROJ,
  output logic [31:0]       PAT_IDX,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              OVERRUN,
  output logic [2:0]        STATE
);

  localparam logic [31:0] ROW_TIME = 32'(C_NUM_ROWS * C_MASK_DES_L);

  logic stream_s, stream_rise, stream_fall;

  sync_edge_det #(.C_STAGES(C_SYNC_STAGES)) u_stream_sync (
    .clk   (CLK_HS),
    .rst   (RESET),
    .d     (STREAM),
    .level (stream_s),
    .rise  (stream_rise),
    .fall  (stream_fall)
  );

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [C_PW_W-1:0]   pcnt_q, pcnt_d;
  logic [31:0]         tgt_q, tgt_d;
  logic [C_PW_W-1:0]   pw_q, pw_d;
  logic [31:0]         num_pat_q, num_pat_d;
  logic [31:0]         pat_idx_q, pat_idx_d;
  logic                trig_q, trig_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    tgt_d     = tgt_q;
    pw_d      = pw_q;
    num_pat_d = num_pat_q;
    pat_idx_d = pat_idx_q;
    trig_d    = trig_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;

    if (!ENABLE) begin
      state_d = S_IDLE;
      trig_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (FRAME_START) begin
            // Target is latched rather than PROJ_DELAY so mid-frame writes cannot move it.
            tgt_d     = sat_sub32(ROW_TIME, PROJ_DELAY);
            pw_d      = PULSE_WIDTH;
            num_pat_d = NUM_PAT;
            pat_idx_d = '0;
            ovr_d     = 1'b0;
            state_d   = S_SKIP;
          end
        end
        S_SKIP: begin
          if (stream_fall) state_d = S_ARM;
        end
        S_ARM: begin
          if (stream_rise) begin
            if (pat_idx_q == num_pat_q) begin
              state_d = S_FLUSH;
            end else begin
              cnt_d   = tgt_q;
              state_d = S_WAIT_DLY;
            end
          end
        end
        S_WAIT_DLY: begin
          if (stream_fall && (cnt_q != '0)) begin
            ovr_d     = 1'b1;
            pat_idx_d = pat_idx_q + 32'd1;
            state_d   = S_ARM;
          end else if (cnt_q == '0) begin
            trig_d  = 1'b1;
            pcnt_d  = (pw_q == '0) ? '0 : (pw_q - C_PW_W'(1));
            state_d = S_PULSE;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_PULSE: begin
          if (stream_rise) ovr_d = 1'b1;
          if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - C_PW_W'(1);
          end else begin
            trig_d    = 1'b0;
            pat_idx_d = pat_idx_q + 32'd1;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (stream_rise) ovr_d = 1'b1;
          if (!stream_s) state_d = S_ARM;
        end
        S_FLUSH: begin
          if (stream_fall) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      tgt_q     <= '0;
      pw_q      <= '0;
      num_pat_q <= '0;
      pat_idx_q <= '0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      tgt_q     <= tgt_d;
      pw_q      <= pw_d;
      num_pat_q <= num_pat_d;
      pat_idx_q <= pat_idx_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign TRIGGER_PROJ = trig_q;
  assign PAT_IDX      = pat_idx_q;
  assign BUSY         = (state_q != S_IDLE);
  assign FRAME_DONE   = done_q;
  assign OVERRUN      = ovr_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_proj_trig_sched.sv
// Directed bench for proj_trig_sched. Inputs change on the falling edge, so
// the next rising edge is E0 of any STREAM transition; a monitor samples 1ns
// after each rising edge and logs trigger edges/widths and FRAME_DONE.
module tb_proj_trig_sched;

  logic        CLK_HS = 1'b0;
  logic        RESET, ENABLE, FRAME_START, STREAM;
  logic [31:0] PROJ_DELAY, NUM_PAT;
  logic [15:0] PULSE_WIDTH;
  logic        TRIGGER_PROJ, BUSY, FRAME_DONE, OVERRUN;
  logic [31:0] PAT_IDX;
  logic [2:0]  STATE;

  proj_trig_sched #(
    .C_NUM_ROWS    (160),
    .C_MASK_DES_L  (18),
    .C_SYNC_STAGES (2),
    .C_PW_W        (16)
  ) dut (
    .CLK_HS       (CLK_HS),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .FRAME_START  (FRAME_START),
    .STREAM       (STREAM),
    .PROJ_DELAY   (PROJ_DELAY),
    .PULSE_WIDTH  (PULSE_WIDTH),
    .NUM_PAT      (NUM_PAT),
    .TRIGGER_PROJ (TRIGGER_PROJ),
    .PAT_IDX      (PAT_IDX),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE),
    .OVERRUN      (OVERRUN),
    .STATE        (STATE)
  );

  always #5 CLK_HS = ~CLK_HS;

  int unsigned cyc = 0;
  always @(posedge CLK_HS) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Trigger / frame-done monitor
  int unsigned n_rise = 0;
  int unsigned n_done = 0;
  int unsigned done_cyc = 0;
  int unsigned rise_cyc [8];
  int unsigned width [8];
  logic        trig_prev = 1'b0;

  always @(posedge CLK_HS) begin
    #1;
    if (TRIGGER_PROJ && !trig_prev) begin
      if (n_rise < 8) rise_cyc[n_rise] = cyc;
      n_rise++;
    end
    if (!TRIGGER_PROJ && trig_prev && n_rise > 0 && n_rise <= 8)
      width[n_rise-1] = cyc - rise_cyc[n_rise-1];
    if (FRAME_DONE) begin
      n_done++;
      done_cyc = cyc;
    end
    trig_prev = TRIGGER_PROJ;
  end

  task automatic arm(input logic [31:0] np, input logic [31:0] pd, input logic [15:0] pw);
    @(negedge CLK_HS);
    NUM_PAT     = np;
    PROJ_DELAY  = pd;
    PULSE_WIDTH = pw;
    ENABLE      = 1'b1;
    FRAME_START = 1'b1;
    @(negedge CLK_HS);
    FRAME_START = 1'b0;
    n_rise = 0;
    n_done = 0;
  endtask

  // One STREAM burst: hi edges sample high, then lo cycles of idle
  task automatic burst(input int unsigned hi, input int unsigned lo, output int unsigned e0);
    @(negedge CLK_HS);
    STREAM = 1'b1;
    e0 = cyc + 1;
    repeat (hi) @(negedge CLK_HS);
    STREAM = 1'b0;
    repeat (lo) @(negedge CLK_HS);
  endtask

  int unsigned e [5];

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; FRAME_START = 1'b0; STREAM = 1'b0;
    PROJ_DELAY = '0; NUM_PAT = '0; PULSE_WIDTH = '0;
    repeat (3) @(negedge CLK_HS);
    check("rst_trig",    32'(TRIGGER_PROJ), 32'd0);
    check("rst_pat_idx", PAT_IDX,           32'd0);
    check("rst_busy",    32'(BUSY),         32'd0);
    check("rst_done",    32'(FRAME_DONE),   32'd0);
    check("rst_ovr",     32'(OVERRUN),      32'd0);
    check("rst_state",   32'(STATE),        32'd0);
    RESET = 1'b0;

    // Nominal frame: tgt = 2880-100 = 2780, trigger at E(2783), 10 wide
    arm(32'd3, 32'd100, 16'd10);
    check("f1_state_skip", 32'(STATE), 32'd1);
    check("f1_busy",       32'(BUSY),  32'd1);
    for (int i = 0; i < 5; i++) burst(2880, 40, e[i]);
    check("f1_n_trig", n_rise, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("f1_rise_cyc", rise_cyc[i], e[i+1] + 32'd2783);
      check("f1_width",    width[i],    32'd10);
    end
    check("f1_n_done",    n_done,          32'd1);
    check("f1_done_cyc",  done_cyc,        e[4] + 32'd2880 + 32'd2);
    check("f1_pat_idx",   PAT_IDX,         32'd3);
    check("f1_ovr",       32'(OVERRUN),    32'd0);
    check("f1_idle",      32'(STATE),      32'd0);
    check("f1_busy_end",  32'(BUSY),       32'd0);

    // Saturated target: PROJ_DELAY > 2880 gives tgt = 0, trigger at E3
    arm(32'd2, 32'd5000, 16'd4);
    for (int i = 0; i < 4; i++) burst(100, 40, e[i]);
    check("f2_n_trig", n_rise, 32'd2);
    for (int i = 0; i < 2; i++) begin
      check("f2_rise_cyc", rise_cyc[i], e[i+1] + 32'd3);
      check("f2_width",    width[i],    32'd4);
    end
    check("f2_n_done",  n_done,  32'd1);
    check("f2_pat_idx", PAT_IDX, 32'd2);

    // Short pattern burst ends before target: skipped, OVERRUN set
    arm(32'd2, 32'd100, 16'd10);
    burst(100, 40, e[0]);
    burst(1000, 40, e[1]);
    check("f3_ovr_mid",     32'(OVERRUN), 32'd1);
    check("f3_pat_idx_mid", PAT_IDX,      32'd1);
    check("f3_state_arm",   32'(STATE),   32'd2);
    check("f3_no_trig_yet", n_rise,       32'd0);
    burst(2880, 40, e[2]);
    burst(100, 40, e[3]);
    check("f3_n_trig",   n_rise,       32'd1);
    check("f3_rise_cyc", rise_cyc[0],  e[2] + 32'd2783);
    check("f3_ovr",      32'(OVERRUN), 32'd1);
    check("f3_pat_idx",  PAT_IDX,      32'd2);
    check("f3_n_done",   n_done,       32'd1);

    // NUM_PAT = 0: second burst is the flush; arm clears OVERRUN
    arm(32'd0, 32'd100, 16'd10);
    check("f4_ovr_clr", 32'(OVERRUN), 32'd0);
    burst(100, 40, e[0]);
    burst(100, 40, e[1]);
    check("f4_n_trig",   n_rise,   32'd0);
    check("f4_n_done",   n_done,   32'd1);
    check("f4_done_cyc", done_cyc, e[1] + 32'd102);
    check("f4_pat_idx",  PAT_IDX,  32'd0);

    // ENABLE low mid-frame: IDLE, PAT_IDX retained
    arm(32'd3, 32'd2880, 16'd5);
    burst(50, 40, e[0]);
    burst(50, 40, e[1]);
    check("f5_n_trig", n_rise, 32'd1);
    ENABLE = 1'b0;
    @(negedge CLK_HS);
    check("f5_en_state",   32'(STATE),        32'd0);
    check("f5_en_trig",    32'(TRIGGER_PROJ), 32'd0);
    check("f5_en_pat_idx", PAT_IDX,           32'd1);

    // RESET mid-PULSE after an overrun: tgt = 100, PW = 100
    arm(32'd2, 32'd2780, 16'd100);
    burst(50, 40, e[0]);
    burst(50, 40, e[1]);
    check("f6_ovr_set", 32'(OVERRUN), 32'd1);
    @(negedge CLK_HS);
    STREAM = 1'b1;
    begin
      int unsigned t = 0;
      while (!TRIGGER_PROJ && t < 300) begin
        @(negedge CLK_HS);
        t++;
      end
    end
    check("f6_trig_seen", 32'(TRIGGER_PROJ), 32'd1);
    repeat (5) @(negedge CLK_HS);
    RESET = 1'b1;
    @(negedge CLK_HS);
    check("f6_rst_trig",    32'(TRIGGER_PROJ), 32'd0);
    check("f6_rst_state",   32'(STATE),        32'd0);
    check("f6_rst_busy",    32'(BUSY),         32'd0);
    check("f6_rst_ovr",     32'(OVERRUN),      32'd0);
    check("f6_rst_pat_idx", PAT_IDX,           32'd0);
    RESET  = 1'b0;
    STREAM = 1'b0;
    repeat (10) @(negedge CLK_HS);

    // Re-arm; FRAME_START while busy ignored, NUM_PAT change not latched; PW=0 acts as 1
    arm(32'd1, 32'd2880, 16'd0);
    check("f7_state_skip", 32'(STATE), 32'd1);
    NUM_PAT     = 32'd5;
    FRAME_START = 1'b1;
    @(negedge CLK_HS);
    FRAME_START = 1'b0;
    check("f7_restart_ign", 32'(STATE), 32'd1);
    burst(50, 40, e[0]);
    burst(50, 40, e[1]);
    burst(50, 40, e[2]);
    check("f7_n_trig",   n_rise,      32'd1);
    check("f7_rise_cyc", rise_cyc[0], e[1] + 32'd3);
    check("f7_width",    width[0],    32'd1);
    check("f7_n_done",   n_done,      32'd1);
    check("f7_pat_idx",  PAT_IDX,     32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
